// File: rtl/branch_predictor.sv
// Bimodal branch predictor with 2-bit saturating counters, decode-stage
// misprediction detection/redirect, and resolved/mispredicted branch counters.
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            brF,
   input  logic [XLEN-1:0] pcF,
   input  logic [XLEN-1:0] immF,
   output logic            predict_takenF,
   output logic [XLEN-1:0] pc_predF,
   input  logic            branchD,
   input  logic            take_branchD,
   input  logic            predictedD,
   input  logic [XLEN-1:0] pcD,
   input  logic [XLEN-1:0] pc_targetD,
   input  logic            stallD,
   output logic            mispredictD,
   output logic [XLEN-1:0] redirect_pc,
   output logic            busy,
   output logic [31:0]     br_count,
   output logic [31:0]     mispred_count
);

   localparam int IDXW = $clog2(ENTRIES);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [IDXW-1:0] sweep_idx;
   logic            sweep_done;

   logic [1:0]      ctr [ENTRIES];
   logic [IDXW-1:0] idx_f;
   logic [IDXW-1:0] idx_d;
   logic [1:0]      ctr_f;
   logic [1:0]      ctr_d;
   logic [1:0]      ctr_d_next;
   logic            resolve;

   logic            unused_bits;

   assign idx_f      = pcF[IDXW+1:2];
   assign idx_d      = pcD[IDXW+1:2];
   assign ctr_f      = ctr[idx_f];
   assign ctr_d      = ctr[idx_d];
   assign resolve    = branchD & ~stallD;
   assign sweep_done = (sweep_idx == IDXW'(ENTRIES - 1));

   assign unused_bits = ^{pcF[XLEN-1:IDXW+2], pcF[1:0],
                          pcD[XLEN-1:IDXW+2], pcD[1:0], ctr_f[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         sweep_idx <= '0;
      end else begin
         state <= state_next;
         if (state == INIT) begin
            sweep_idx <= sweep_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (sweep_done) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = INIT;
      endcase
   end

   always_comb begin
      ctr_d_next = ctr_d;
      if (take_branchD) begin
         if (ctr_d != 2'b11) ctr_d_next = ctr_d + 2'b01;
      end else begin
         if (ctr_d != 2'b00) ctr_d_next = ctr_d - 2'b01;
      end
   end

   // The sweep owns the single write port during INIT; fetch reads the old
   // value on a same-index collision because the write lands on the edge.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         ctr[sweep_idx] <= 2'b01;
      end else if (resolve) begin
         ctr[idx_d] <= ctr_d_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         if (resolve)     br_count      <= br_count + 32'd1;
         if (mispredictD) mispred_count <= mispred_count + 32'd1;
      end
   end

   assign busy           = (state == INIT);
   assign predict_takenF = (state == RUN) & brF & ctr_f[1];
   assign pc_predF       = predict_takenF ? (pcF + immF) : (pcF + XLEN'(4));
   assign mispredictD    = resolve & (take_branchD != predictedD);
   assign redirect_pc    = take_branchD ? pc_targetD : (pcD + XLEN'(4));

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against an integer-counter reference model.
module tb_branch_predictor;

   localparam int ENTRIES = 64;
   localparam int XLEN    = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            brF;
   logic [XLEN-1:0] pcF;
   logic [XLEN-1:0] immF;
   logic            predict_takenF;
   logic [XLEN-1:0] pc_predF;
   logic            branchD;
   logic            take_branchD;
   logic            predictedD;
   logic [XLEN-1:0] pcD;
   logic [XLEN-1:0] pc_targetD;
   logic            stallD;
   logic            mispredictD;
   logic [XLEN-1:0] redirect_pc;
   logic            busy;
   logic [31:0]     br_count;
   logic [31:0]     mispred_count;

   int total = 0;
   int bad   = 0;

   // Reference model: counters as plain integers 0..3, init progress as a cycle count.
   int          m_ctr [ENTRIES];
   bit          m_run;
   int          m_init;
   logic [31:0] m_br;
   logic [31:0] m_mis;

   always #5 clk = ~clk;

   branch_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .brF            (brF),
      .pcF            (pcF),
      .immF           (immF),
      .predict_takenF (predict_takenF),
      .pc_predF       (pc_predF),
      .branchD        (branchD),
      .take_branchD   (take_branchD),
      .predictedD     (predictedD),
      .pcD            (pcD),
      .pc_targetD     (pc_targetD),
      .stallD         (stallD),
      .mispredictD    (mispredictD),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .br_count       (br_count),
      .mispred_count  (mispred_count)
   );

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic logic exp_pred(logic br, logic [31:0] pc);
      return logic'(m_run && br && (m_ctr[idx_of(pc)] >= 2));
   endfunction

   function automatic logic [31:0] exp_pc_pred(logic br, logic [31:0] pc, logic [31:0] imm);
      return exp_pred(br, pc) ? pc + imm : pc + 32'd4;
   endfunction

   function automatic logic exp_mis();
      return logic'(branchD && !stallD && (take_branchD != predictedD));
   endfunction

   function automatic logic [31:0] exp_redirect();
      return take_branchD ? pc_targetD : pcD + 32'd4;
   endfunction

   task automatic model_reset();
      m_run  = 1'b0;
      m_init = 0;
      m_br   = '0;
      m_mis  = '0;
   endtask

   // Advance the model by one clock using the inputs applied before the edge.
   task automatic clock_edge();
      bit res;
      int i;
      res = branchD && !stallD;
      if (res) begin
         m_br = m_br + 1;
         if (take_branchD != predictedD) m_mis = m_mis + 1;
         if (m_run) begin
            i = idx_of(pcD);
            if (take_branchD) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else              m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end
      end
      if (!m_run) begin
         m_init++;
         if (m_init == ENTRIES) begin
            m_run = 1'b1;
            foreach (m_ctr[k]) m_ctr[k] = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      brF          = 1'b0;
      pcF          = '0;
      immF         = '0;
      branchD      = 1'b0;
      take_branchD = 1'b0;
      predictedD   = 1'b0;
      pcD          = '0;
      pc_targetD   = '0;
      stallD       = 1'b0;
   endtask

   task automatic drive_branch(logic [31:0] pc, logic take, logic pred, logic [31:0] tgt, logic stall);
      branchD      = 1'b1;
      pcD          = pc;
      take_branchD = take;
      predictedD   = pred;
      pc_targetD   = tgt;
      stallD       = stall;
   endtask

   // Assert reset asynchronously mid-cycle and release it on the next falling edge.
   task automatic do_reset(string tag);
      set_idle();
      brF = 1'b1;
      pcF = 32'h100;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL %s_busy: got %b want 1", tag, busy); end
      total++; if (predict_takenF !== 1'b0) begin bad++; $display("[TB] FAIL %s_pred: got %b want 0", tag, predict_takenF); end
      total++; if (mispredictD !== 1'b0) begin bad++; $display("[TB] FAIL %s_mis: got %b want 0", tag, mispredictD); end
      total++; if (br_count !== 32'd0) begin bad++; $display("[TB] FAIL %s_brcnt: got %0d want 0", tag, br_count); end
      total++; if (mispred_count !== 32'd0) begin bad++; $display("[TB] FAIL %s_miscnt: got %0d want 0", tag, mispred_count); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // Count busy cycles until RUN, checking predictions stay 0 throughout.
   task automatic run_init(string tag);
      int busy_cycles;
      busy_cycles = 0;
      for (int i = 0; i < 200 && busy === 1'b1; i++) begin
         brF  = 1'b1;
         pcF  = $urandom();
         immF = $urandom();
         #1;
         total++;
         if (predict_takenF !== 1'b0 || pc_predF !== pcF + 32'd4) begin
            bad++;
            $display("[TB] FAIL %s_init_pred: got %b/%h want 0/%h", tag, predict_takenF, pc_predF, pcF + 32'd4);
         end
         busy_cycles++;
         clock_edge();
      end
      total++;
      if (busy_cycles !== ENTRIES) begin
         bad++;
         $display("[TB] FAIL %s_busy_len: got %0d want %0d", tag, busy_cycles, ENTRIES);
      end
      total++;
      if (busy !== !m_run) begin bad++; $display("[TB] FAIL %s_busy_end: got %b want %b", tag, busy, !m_run); end
   endtask

   task automatic test_reset();
      do_reset("reset");
      run_init("reset");
      for (int i = 0; i < 8; i++) begin
         brF  = 1'b1;
         pcF  = $urandom();
         immF = $urandom();
         #1;
         total++;
         if (predict_takenF !== 1'b0) begin bad++; $display("[TB] FAIL fresh_pred: pc=%h got %b want 0", pcF, predict_takenF); end
         clock_edge();
      end
   endtask

   task automatic test_train();
      set_idle();
      for (int i = 0; i < 2; i++) begin
         drive_branch(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
         #1;
         total++; if (mispredictD !== 1'b1) begin bad++; $display("[TB] FAIL train_mis: got %b want 1", mispredictD); end
         total++; if (redirect_pc !== 32'h80) begin bad++; $display("[TB] FAIL train_redir: got %h want 00000080", redirect_pc); end
         clock_edge();
      end
      set_idle();
      brF  = 1'b1;
      pcF  = 32'h100;
      immF = -32'sd128;
      #1;
      total++; if (predict_takenF !== 1'b1) begin bad++; $display("[TB] FAIL train_pred: got %b want 1", predict_takenF); end
      total++; if (pc_predF !== 32'h80) begin bad++; $display("[TB] FAIL train_pcpred: got %h want 00000080", pc_predF); end
      clock_edge();
   endtask

   task automatic test_saturate();
      logic want;
      set_idle();
      for (int i = 0; i < 6; i++) begin
         drive_branch(32'h100, (i < 4), exp_pred(1'b1, 32'h100), 32'h80, 1'b0);
         #1;
         total++;
         if (mispredictD !== exp_mis()) begin bad++; $display("[TB] FAIL sat_mis%0d: got %b want %b", i, mispredictD, exp_mis()); end
         clock_edge();
         branchD = 1'b0;
         brF     = 1'b1;
         pcF     = 32'h100;
         #1;
         want = (i < 5) ? 1'b1 : 1'b0;
         total++;
         if (predict_takenF !== want) begin bad++; $display("[TB] FAIL sat_pred%0d: got %b want %b", i, predict_takenF, want); end
      end
      total++;
      if (mispred_count !== m_mis) begin bad++; $display("[TB] FAIL sat_miscnt: got %0d want %0d", mispred_count, m_mis); end
      clock_edge();
   endtask

   task automatic test_nt_mispredict();
      set_idle();
      drive_branch(32'h200, 1'b0, 1'b1, 32'h1000, 1'b0);
      #1;
      total++; if (mispredictD !== 1'b1) begin bad++; $display("[TB] FAIL nt_mis: got %b want 1", mispredictD); end
      total++; if (redirect_pc !== 32'h204) begin bad++; $display("[TB] FAIL nt_redir: got %h want 00000204", redirect_pc); end
      clock_edge();
      for (int i = 0; i < 2; i++) begin
         drive_branch(32'h200, 1'b1, 1'b0, 32'h1000, 1'b0);
         #1;
         clock_edge();
      end
      set_idle();
      brF = 1'b1;
      pcF = 32'h100;
      #1;
      total++; if (predict_takenF !== 1'b1) begin bad++; $display("[TB] FAIL alias_pred: got %b want 1", predict_takenF); end
      clock_edge();
   endtask

   task automatic test_stall();
      logic [31:0] br_before;
      set_idle();
      br_before = m_br;
      for (int i = 0; i < 3; i++) begin
         drive_branch(32'h104, 1'b1, 1'b0, 32'h400, 1'b1);
         brF = 1'b1;
         pcF = 32'h104;
         #1;
         total++; if (mispredictD !== 1'b0) begin bad++; $display("[TB] FAIL stall_mis%0d: got %b want 0", i, mispredictD); end
         clock_edge();
      end
      #1;
      total++; if (br_count !== br_before) begin bad++; $display("[TB] FAIL stall_brcnt: got %0d want %0d", br_count, br_before); end
      total++; if (predict_takenF !== 1'b0) begin bad++; $display("[TB] FAIL stall_pred: got %b want 0", predict_takenF); end
      stallD = 1'b0;
      #1;
      total++; if (mispredictD !== 1'b1) begin bad++; $display("[TB] FAIL unstall_mis: got %b want 1", mispredictD); end
      clock_edge();
      branchD = 1'b0;
      #1;
      total++; if (br_count !== br_before + 32'd1) begin bad++; $display("[TB] FAIL unstall_brcnt: got %0d want %0d", br_count, br_before + 32'd1); end
      total++; if (predict_takenF !== 1'b1) begin bad++; $display("[TB] FAIL unstall_pred: got %b want 1", predict_takenF); end
      clock_edge();
   endtask

   // Random traffic on a small PC pool so fetch/decode often collide and alias.
   task automatic test_random(int cycles);
      logic [31:0] pool_pc;
      for (int i = 0; i < cycles; i++) begin
         pool_pc      = 32'h100 + 32'(4 * $urandom_range(0, 7)) + ($urandom_range(0, 1) ? 32'h100 : 32'h0);
         branchD      = ($urandom_range(0, 9) < 6);
         stallD       = ($urandom_range(0, 3) == 0);
         pcD          = pool_pc;
         take_branchD = $urandom_range(0, 1);
         predictedD   = $urandom_range(0, 1) ? exp_pred(1'b1, pool_pc) : 1'($urandom_range(0, 1));
         pc_targetD   = $urandom();
         brF          = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       pcF = pcD;
            1:       pcF = 32'hFFFF_FFFC;
            2:       pcF = $urandom();
            default: pcF = 32'h100 + 32'(4 * $urandom_range(0, 7));
         endcase
         immF = $urandom();
         #1;
         total++;
         if (predict_takenF !== exp_pred(brF, pcF) || pc_predF !== exp_pc_pred(brF, pcF, immF)) begin
            bad++;
            $display("[TB] FAIL rand_fetch%0d: got %b/%h want %b/%h", i, predict_takenF, pc_predF,
                     exp_pred(brF, pcF), exp_pc_pred(brF, pcF, immF));
         end
         total++;
         if (mispredictD !== exp_mis() || (exp_mis() && redirect_pc !== exp_redirect())) begin
            bad++;
            $display("[TB] FAIL rand_dec%0d: got %b/%h want %b/%h", i, mispredictD, redirect_pc, exp_mis(), exp_redirect());
         end
         total++;
         if (br_count !== m_br || mispred_count !== m_mis || busy !== !m_run) begin
            bad++;
            $display("[TB] FAIL rand_cnt%0d: got %0d/%0d/%b want %0d/%0d/%b", i, br_count, mispred_count, busy,
                     m_br, m_mis, !m_run);
         end
         clock_edge();
      end
      set_idle();
   endtask

   task automatic test_reset_mid();
      do_reset("mid_a");
      for (int i = 0; i < 30; i++) begin
         drive_branch(32'h100, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h40, 1'($urandom_range(0, 3) == 0));
         #1;
         total++;
         if (mispredictD !== exp_mis()) begin bad++; $display("[TB] FAIL init_mis%0d: got %b want %b", i, mispredictD, exp_mis()); end
         clock_edge();
      end
      total++;
      if (br_count !== m_br || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL init_cnt: got %0d/%b want %0d/1", br_count, busy, m_br);
      end
      do_reset("mid_init");
      run_init("mid_init");
      test_random(40);
      do_reset("mid_run");
      run_init("mid_run");
      brF = 1'b1;
      pcF = 32'h100;
      #1;
      total++; if (predict_takenF !== 1'b0) begin bad++; $display("[TB] FAIL rerun_pred: got %b want 0", predict_takenF); end
      clock_edge();
   endtask

   initial begin
      set_idle();
      rst_n = 1'b1;
      model_reset();
      foreach (m_ctr[k]) m_ctr[k] = 1;
      #3;
      test_reset();
      test_train();
      test_saturate();
      test_nt_mispredict();
      test_stall();
      test_random(400);
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
